// File: rtl/csr_access_ctrl.sv
// Zicsr initiator: sequences one read-modify-write against the machine CSR file.
// Latency: accept -> READ -> WRITE -> RESP (3 cycles), illegal requests respond 1 cycle after accept.
// Backpressure: req_ready is high only in IDLE with no flush; the pipeline stalls while busy.
module csr_access_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] csr_addr_i,
  input  logic [4:0]        rs1_idx,
  input  logic [4:0]        rd_idx,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic              flush,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  output logic              csr_rd,
  output logic              csr_wr,
  input  logic [DATA_W-1:0] rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              illegal
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t            state;
  logic [2:0]        f3_q;
  logic [4:0]        rs1_q;
  logic [DATA_W-1:0] rs1d_q;
  logic [DATA_W-1:0] old_q;

  logic              legal_f3;
  logic              legal_addr;
  logic              req_legal;
  logic              rd_en_in;
  logic              do_write;
  logic [DATA_W-1:0] src;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] wdata_nxt;

  assign req_ready  = (state == IDLE) && !flush;
  assign legal_f3   = (funct3 != 3'b000) && (funct3 != 3'b100);
  assign legal_addr = (csr_addr_i == ADDR_W'(12'h300)) || (csr_addr_i == ADDR_W'(12'h304)) ||
                      (csr_addr_i == ADDR_W'(12'h341)) || (csr_addr_i == ADDR_W'(12'h344));
  assign req_legal  = legal_f3 && legal_addr;
  // CSRRW/CSRRWI to x0 must not cause read side effects
  assign rd_en_in   = !((funct3[1:0] == 2'b01) && (rd_idx == 5'd0));
  assign do_write   = (f3_q[1:0] == 2'b01) || (rs1_q != 5'd0);
  assign src        = f3_q[2] ? {{(DATA_W-5){1'b0}}, rs1_q} : rs1d_q;
  assign rd_val     = csr_rd ? rdata : '0;

  always_comb begin
    wdata_nxt = '0;
    case (f3_q[1:0])
      2'b01:   wdata_nxt = src;
      2'b10:   wdata_nxt = rd_val | src;
      2'b11:   wdata_nxt = rd_val & ~src;
      default: wdata_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      csr_rd    <= 1'b0;
      csr_wr    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      illegal   <= 1'b0;
      f3_q      <= '0;
      rs1_q     <= '0;
      rs1d_q    <= '0;
      old_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            f3_q   <= funct3;
            rs1_q  <= rs1_idx;
            rs1d_q <= rs1_data;
            addr   <= csr_addr_i;
            if (req_legal) begin
              state  <= READ;
              csr_rd <= rd_en_in;
            end else begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              illegal   <= 1'b1;
              rsp_data  <= '0;
            end
          end
        end
        READ: begin
          // old value captured here so the response is always pre-write
          csr_rd <= 1'b0;
          old_q  <= rd_val;
          if (flush) begin
            state <= IDLE;
          end else begin
            state  <= WRITE;
            csr_wr <= do_write;
            wdata  <= wdata_nxt;
          end
        end
        WRITE: begin
          csr_wr <= 1'b0;
          wdata  <= '0;
          if (flush) begin
            state <= IDLE;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= old_q;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          illegal   <= 1'b0;
          rsp_data  <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
